// File: rtl/rat_pipe_pkg.sv
// Shared types and constants for the RAT pipeline hazard/interrupt control.
package rat_pipe_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_PUSH   = 2'd2,
        HZ_VECTOR = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF         = 2'b00;
    localparam logic [1:0] FWD_EX         = 2'b01;
    localparam logic [1:0] FWD_WB         = 2'b10;
    localparam logic [1:0] RF_WR_SEL_LOAD = 2'b01;

    // EX result is newer than WB, so an EX hit wins over a WB hit.
    function automatic logic [1:0] fwd_pick(input logic used, input logic ex_hit, input logic wb_hit);
        logic [1:0] sel;
        if (!used) begin
            sel = FWD_RF;
        end else if (ex_hit) begin
            sel = FWD_EX;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational operand-forwarding compare for both decode source operands.
module fwd_unit
    import rat_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              dec_valid,
    input  logic              dec_use_x,
    input  logic              dec_use_y,
    input  logic [REG_AW-1:0] dec_addr_x,
    input  logic [REG_AW-1:0] dec_addr_y,
    input  logic              ex_rf_wr,
    input  logic [1:0]        ex_rf_wr_sel,
    input  logic [REG_AW-1:0] ex_wb_addr,
    input  logic              wb_rf_wr,
    input  logic [REG_AW-1:0] wb_addr,
    output logic [1:0]        fwd_x_sel,
    output logic [1:0]        fwd_y_sel
);

    logic ex_fwd_ok_s;

    // A load's data is not ready in EX, so only non-load EX writes may forward.
    assign ex_fwd_ok_s = ex_rf_wr && (ex_rf_wr_sel != RF_WR_SEL_LOAD);

    // Select per operand.
    always_comb begin
        fwd_x_sel = fwd_pick(dec_valid && dec_use_x,
                             ex_fwd_ok_s && (dec_addr_x == ex_wb_addr),
                             wb_rf_wr && (dec_addr_x == wb_addr));
        fwd_y_sel = fwd_pick(dec_valid && dec_use_y,
                             ex_fwd_ok_s && (dec_addr_y == ex_wb_addr),
                             wb_rf_wr && (dec_addr_y == wb_addr));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side hazard and interrupt sequencer: bubbles, stalls, flushes,
// interrupt push/vector strobes and operand forwarding selects.
module pipeline_hazard_ctrl
    import rat_pipe_pkg::*;
#(
    parameter int          REG_AW  = 5,
    parameter logic [9:0]  INT_VEC = 10'h3FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic              dec_use_x,
    input  logic              dec_use_y,
    input  logic [REG_AW-1:0] dec_addr_x,
    input  logic [REG_AW-1:0] dec_addr_y,
    input  logic              ex_rf_wr,
    input  logic [1:0]        ex_rf_wr_sel,
    input  logic [REG_AW-1:0] ex_wb_addr,
    input  logic              wb_rf_wr,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              ex_branch_taken,
    input  logic              int_req,
    input  logic              i_flag,
    output logic              nop,
    output logic              interupt,
    output logic              fetch_stall,
    output logic              if_flush,
    output logic              pc_int_ld,
    output logic              int_ack,
    output logic [1:0]        fwd_x_sel,
    output logic [1:0]        fwd_y_sel
);

    hz_state_t   state_q;
    hz_state_t   state_d;
    logic        lu_s;
    logic [9:0]  unused_int_vec_s;

    // The PC mux consumes the vector itself; kept here for reference.
    assign unused_int_vec_s = INT_VEC;

    // Load-use hazard: decode needs a value still being loaded in EX.
    assign lu_s = dec_valid && ex_rf_wr && (ex_rf_wr_sel == RF_WR_SEL_LOAD) &&
                  ((dec_use_x && (dec_addr_x == ex_wb_addr)) ||
                   (dec_use_y && (dec_addr_y == ex_wb_addr)));

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .dec_valid    (dec_valid),
        .dec_use_x    (dec_use_x),
        .dec_use_y    (dec_use_y),
        .dec_addr_x   (dec_addr_x),
        .dec_addr_y   (dec_addr_y),
        .ex_rf_wr     (ex_rf_wr),
        .ex_rf_wr_sel (ex_rf_wr_sel),
        .ex_wb_addr   (ex_wb_addr),
        .wb_rf_wr     (wb_rf_wr),
        .wb_addr      (wb_addr),
        .fwd_x_sel    (fwd_x_sel),
        .fwd_y_sel    (fwd_y_sel)
    );

    // Next-state and output decode; outputs are combinational so the control
    // vector register samples them on the same edge.
    always_comb begin
        state_d     = state_q;
        nop         = 1'b0;
        interupt    = 1'b0;
        fetch_stall = 1'b0;
        if_flush    = 1'b0;
        pc_int_ld   = 1'b0;
        int_ack     = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (ex_branch_taken) begin
                    if_flush = 1'b1;
                    nop      = 1'b1;
                end else if (lu_s) begin
                    nop         = 1'b1;
                    fetch_stall = 1'b1;
                end else begin
                    nop = 1'b0;
                end
                if (int_req && i_flag && !lu_s && !ex_branch_taken) begin
                    state_d = HZ_DRAIN;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            HZ_DRAIN: begin
                nop = 1'b1;
                // A branch resolving now must be flushed before the push.
                if (ex_branch_taken) begin
                    if_flush = 1'b1;
                    state_d  = HZ_DRAIN;
                end else begin
                    fetch_stall = 1'b1;
                    state_d     = HZ_PUSH;
                end
            end
            HZ_PUSH: begin
                interupt    = 1'b1;
                fetch_stall = 1'b1;
                state_d     = HZ_VECTOR;
            end
            HZ_VECTOR: begin
                pc_int_ld = 1'b1;
                if_flush  = 1'b1;
                int_ack   = 1'b1;
                nop       = 1'b1;
                state_d   = HZ_RUN;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
